// File: rtl/imu_frame_arbiter_if.sv
// rtl/imu_frame_arbiter_if.sv - output sample handshake bundle for imu_frame_arbiter
//
// Purpose: groups the arbiter's outgoing sample stream and its ready return.
// Ports (signals):
//   m_valid  - sample presented (arbiter -> formatter)
//   m_ready  - formatter accepts the sample (formatter -> arbiter)
//   m_src    - source index of the presented sample
//   m_data   - {w,x,y,z,gx,gy,gz}, seven signed 16-bit fields, w in MSBs
//   m_flags  - bit0 orientation valid, bit1 gyro valid
// Modports: master = arbiter side, slave = formatter side.

interface imu_frame_arbiter_if;
  logic         m_valid;
  logic         m_ready;
  logic         m_src;
  logic [111:0] m_data;
  logic [1:0]   m_flags;

  modport master (output m_valid, m_src, m_data, m_flags, input m_ready);
  modport slave  (input m_valid, m_src, m_data, m_flags, output m_ready);
endinterface

// File: rtl/imu_frame_arbiter.sv
// rtl/imu_frame_arbiter.sv - two-source IMU sample arbiter with overwrite counting
//
// Purpose: captures samples from two IMU sources into holding registers and
// forwards them one at a time, round-robin, over a valid/ready stream.
// Optional build macro: LINK_WATCHDOG_EN (per-source stale-link watchdog).
// Ports:
//   clk, reset           - single clock, synchronous active-high reset
//   s0_strobe/data/flags - source 0 sample pulse, 112-bit sample, 2-bit flags
//   s1_strobe/data/flags - source 1, same format
//   m                    - imu_frame_arbiter_if.master output stream
//   drop_cnt0/1          - saturating counts of overwritten, unsent samples
//   link_up              - per-source link-alive status

module imu_frame_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 3000000,
  parameter int unsigned DROP_W         = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s0_strobe,
  input  logic [111:0]               s0_data,
  input  logic [1:0]                 s0_flags,
  input  logic                       s1_strobe,
  input  logic [111:0]               s1_data,
  input  logic [1:0]                 s1_flags,
  imu_frame_arbiter_if.master        m,
  output logic [DROP_W-1:0]          drop_cnt0,
  output logic [DROP_W-1:0]          drop_cnt1,
  output logic [1:0]                 link_up
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [1:0]        strobe;
  logic [113:0]      sample [2];
  logic [113:0]      hold_q [2];
  logic [113:0]      hold_d [2];
  logic [DROP_W-1:0] drop_q [2];
  logic [DROP_W-1:0] drop_d [2];
  logic [1:0]        pend_q, pend_d;
  logic [1:0]        link_q, link_d;
  logic [1:0]        stale;
  logic [1:0]        pend_avail;
  logic [1:0]        taken;
  logic              last_q, last_d;
  logic              src_q, src_d;
  logic [113:0]      out_q, out_d;
  logic              grant;
  logic              gnt_src;

  assign strobe    = {s1_strobe, s0_strobe};
  assign sample[0] = {s0_flags, s0_data};
  assign sample[1] = {s1_flags, s1_data};

`ifdef LINK_WATCHDOG_EN
  localparam int unsigned        WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]    WD_MAX = WD_W'(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_q [2];
  logic [WD_W-1:0] wd_d [2];

  // stale[i] marks the edge on which the counter reaches the timeout.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stale[i] = 1'b0;
      wd_d[i]  = wd_q[i];
      if (strobe[i]) begin
        wd_d[i] = '0;
      end else if (wd_q[i] != WD_MAX) begin
        wd_d[i]  = wd_q[i] + WD_W'(1);
        stale[i] = (wd_q[i] == WD_MAX - WD_W'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) wd_q[i] <= '0;
      else       wd_q[i] <= wd_d[i];
    end
  end
`else
  assign stale = 2'b00;
`endif

  // A source going stale on this edge is not granted: its sample is discarded.
  assign pend_avail = pend_q & ~stale;
  assign grant      = (state_q == IDLE) && (pend_avail != 2'b00);
  assign gnt_src    = (pend_avail == 2'b11) ? ~last_q : pend_avail[1];
  assign taken      = grant ? (gnt_src ? 2'b10 : 2'b01) : 2'b00;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = SEND;
      SEND:    if (m.m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    m.m_valid = (state_q == SEND);
  end

  // Datapath next state. A strobe on the source being granted keeps pend set
  // with the new sample; the old one is the one sent, so no drop is counted.
  always_comb begin
    src_d  = src_q;
    out_d  = out_q;
    last_d = last_q;
    if (grant) begin
      src_d  = gnt_src;
      out_d  = hold_q[gnt_src];
      last_d = gnt_src;
    end
    for (int i = 0; i < 2; i++) begin
      hold_d[i] = hold_q[i];
      pend_d[i] = pend_q[i];
      drop_d[i] = drop_q[i];
      link_d[i] = strobe[i] | (link_q[i] & ~stale[i]);
      if (strobe[i]) begin
        hold_d[i] = sample[i];
        pend_d[i] = 1'b1;
        if (pend_q[i] && !taken[i] && (drop_q[i] != '1)) begin
          drop_d[i] = drop_q[i] + DROP_W'(1);
        end
      end else if (taken[i] || stale[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  // last_q resets to 1 so the first two-way contention favours source 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q  <= 1'b0;
      out_q  <= '0;
      last_q <= 1'b1;
      pend_q <= 2'b00;
      link_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        hold_q[i] <= '0;
        drop_q[i] <= '0;
      end
    end else begin
      src_q  <= src_d;
      out_q  <= out_d;
      last_q <= last_d;
      pend_q <= pend_d;
      link_q <= link_d;
      for (int i = 0; i < 2; i++) begin
        hold_q[i] <= hold_d[i];
        drop_q[i] <= drop_d[i];
      end
    end
  end

  assign m.m_src   = src_q;
  assign m.m_data  = out_q[111:0];
  assign m.m_flags = out_q[113:112];
  assign drop_cnt0 = drop_q[0];
  assign drop_cnt1 = drop_q[1];
  assign link_up   = link_q;

endmodule

// File: tb/tb_imu_frame_arbiter.sv
// tb/tb_imu_frame_arbiter.sv - self-checking bench for imu_frame_arbiter

module tb_imu_frame_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         s0_strobe, s1_strobe;
  logic [111:0] s0_data, s1_data;
  logic [1:0]   s0_flags, s1_flags;
  logic [7:0]   drop_cnt0, drop_cnt1;
  logic [1:0]   link_up;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  imu_frame_arbiter_if bus ();

  imu_frame_arbiter #(.TIMEOUT_CYCLES(10), .DROP_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .s0_strobe (s0_strobe),
    .s0_data   (s0_data),
    .s0_flags  (s0_flags),
    .s1_strobe (s1_strobe),
    .s1_data   (s1_data),
    .s1_flags  (s1_flags),
    .m         (bus),
    .drop_cnt0 (drop_cnt0),
    .drop_cnt1 (drop_cnt1),
    .link_up   (link_up)
  );

  typedef struct {
    logic        rst;
    logic        s0s;
    logic [15:0] s0x;
    logic [1:0]  s0f;
    logic        s1s;
    logic [15:0] s1x;
    logic [1:0]  s1f;
    logic        rdy;
    logic        ev;
    logic        esrc;
    logic        ezd;
    logic [15:0] ex;
    logic [1:0]  ef;
    logic [7:0]  ed0;
    logic [7:0]  ed1;
    logic [1:0]  elink;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [111:0] mk(input logic [15:0] x);
    return {16'd16384, x, ~x, x + 16'd1, x + 16'd2, x + 16'd3, x + 16'd4};
  endfunction

  task automatic add(input logic rst, input logic s0s, input int s0x, input logic [1:0] s0f,
                     input logic s1s, input int s1x, input logic [1:0] s1f, input logic rdy,
                     input logic ev, input logic esrc, input logic ezd, input int ex,
                     input logic [1:0] ef, input int ed0, input int ed1, input logic [1:0] elink);
    vec_t v;
    v.rst = rst; v.s0s = s0s; v.s0x = 16'(s0x); v.s0f = s0f;
    v.s1s = s1s; v.s1x = 16'(s1x); v.s1f = s1f; v.rdy = rdy;
    v.ev = ev; v.esrc = esrc; v.ezd = ezd; v.ex = 16'(ex); v.ef = ef;
    v.ed0 = 8'(ed0); v.ed1 = 8'(ed1); v.elink = elink;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    s0_strobe = 1'b0; s0_data = '0; s0_flags = '0;
    s1_strobe = 1'b0; s1_data = '0; s1_flags = '0;
    bus.m_ready = 1'b0;

    //  rst s0s s0x  s0f   s1s s1x s1f   rdy  ev src zd  x    f     d0 d1 link
    // reset, then single sample with one-cycle m_valid
    add(1, 0, 0,   2'b00, 0, 0,  2'b00, 1,   0, 0, 1, 0,   2'b00, 0, 0, 2'b00);
    add(0, 0, 0,   2'b00, 0, 0,  2'b00, 1,   0, 0, 1, 0,   2'b00, 0, 0, 2'b00);
    add(0, 1, 100, 2'b11, 0, 0,  2'b00, 1,   0, 0, 1, 0,   2'b00, 0, 0, 2'b01);
    add(0, 0, 0,   2'b00, 0, 0,  2'b00, 1,   1, 0, 0, 100, 2'b11, 0, 0, 2'b01);
    add(0, 0, 0,   2'b00, 0, 0,  2'b00, 1,   0, 0, 0, 100, 2'b11, 0, 0, 2'b01);
    add(0, 0, 0,   2'b00, 0, 0,  2'b00, 1,   0, 0, 0, 100, 2'b11, 0, 0, 2'b01);
    // reset beats simultaneous strobes; then dual contention, repeat during grant
    add(1, 1, 99,  2'b11, 1, 98, 2'b11, 1,   0, 0, 1, 0,   2'b00, 0, 0, 2'b00);
    add(0, 1, 10,  2'b01, 1, 20, 2'b10, 1,   0, 0, 1, 0,   2'b00, 0, 0, 2'b11);
    add(0, 1, 11,  2'b11, 1, 21, 2'b11, 1,   1, 0, 0, 10,  2'b01, 0, 1, 2'b11);
    add(0, 0, 0,   2'b00, 0, 0,  2'b00, 1,   0, 0, 0, 10,  2'b01, 0, 1, 2'b11);
    add(0, 0, 0,   2'b00, 0, 0,  2'b00, 1,   1, 1, 0, 21,  2'b11, 0, 1, 2'b11);
    add(0, 0, 0,   2'b00, 0, 0,  2'b00, 1,   0, 1, 0, 21,  2'b11, 0, 1, 2'b11);
    add(0, 0, 0,   2'b00, 0, 0,  2'b00, 1,   1, 0, 0, 11,  2'b11, 0, 1, 2'b11);
    add(0, 0, 0,   2'b00, 0, 0,  2'b00, 1,   0, 0, 0, 11,  2'b11, 0, 1, 2'b11);
    // backpressure and overwrite on source 1
    add(1, 0, 0,   2'b00, 0, 0,  2'b00, 0,   0, 0, 1, 0,   2'b00, 0, 0, 2'b00);
    add(0, 0, 0,   2'b00, 1, 5,  2'b11, 0,   0, 0, 1, 0,   2'b00, 0, 0, 2'b10);
    add(0, 0, 0,   2'b00, 1, 6,  2'b11, 0,   1, 1, 0, 5,   2'b11, 0, 0, 2'b10);
    add(0, 0, 0,   2'b00, 1, 7,  2'b11, 0,   1, 1, 0, 5,   2'b11, 0, 1, 2'b10);
    add(0, 0, 0,   2'b00, 0, 0,  2'b00, 0,   1, 1, 0, 5,   2'b11, 0, 1, 2'b10);
    add(0, 0, 0,   2'b00, 0, 0,  2'b00, 1,   0, 1, 0, 5,   2'b11, 0, 1, 2'b10);
    add(0, 0, 0,   2'b00, 0, 0,  2'b00, 1,   1, 1, 0, 7,   2'b11, 0, 1, 2'b10);
    add(0, 0, 0,   2'b00, 0, 0,  2'b00, 1,   0, 1, 0, 7,   2'b11, 0, 1, 2'b10);
    // reset while in SEND, then a normal transfer
    add(0, 1, 30,  2'b10, 0, 0,  2'b00, 0,   0, 1, 0, 7,   2'b11, 0, 1, 2'b11);
    add(0, 0, 0,   2'b00, 0, 0,  2'b00, 0,   1, 0, 0, 30,  2'b10, 0, 1, 2'b11);
    add(1, 0, 0,   2'b00, 0, 0,  2'b00, 0,   0, 0, 1, 0,   2'b00, 0, 0, 2'b00);
    add(0, 0, 0,   2'b00, 0, 0,  2'b00, 1,   0, 0, 1, 0,   2'b00, 0, 0, 2'b00);
    add(0, 1, 31,  2'b01, 0, 0,  2'b00, 1,   0, 0, 1, 0,   2'b00, 0, 0, 2'b01);
    add(0, 0, 0,   2'b00, 0, 0,  2'b00, 1,   1, 0, 0, 31,  2'b01, 0, 0, 2'b01);
    add(0, 0, 0,   2'b00, 0, 0,  2'b00, 1,   0, 0, 0, 31,  2'b01, 0, 0, 2'b01);

    @(negedge clk);
    foreach (vecs[i]) begin
      reset       = vecs[i].rst;
      s0_strobe   = vecs[i].s0s;
      s0_data     = mk(vecs[i].s0x);
      s0_flags    = vecs[i].s0f;
      s1_strobe   = vecs[i].s1s;
      s1_data     = mk(vecs[i].s1x);
      s1_flags    = vecs[i].s1f;
      bus.m_ready = vecs[i].rdy;
      step();
      chk("m_valid",   i, 128'(bus.m_valid), 128'(vecs[i].ev));
      chk("m_src",     i, 128'(bus.m_src),   128'(vecs[i].esrc));
      chk("m_data",    i, 128'(bus.m_data),  vecs[i].ezd ? 128'(0) : 128'(mk(vecs[i].ex)));
      chk("m_flags",   i, 128'(bus.m_flags), vecs[i].ezd ? 128'(0) : 128'(vecs[i].ef));
      chk("drop_cnt0", i, 128'(drop_cnt0),   128'(vecs[i].ed0));
      chk("drop_cnt1", i, 128'(drop_cnt1),   128'(vecs[i].ed1));
      chk("link_up",   i, 128'(link_up),     128'(vecs[i].elink));
    end
    s0_strobe = 1'b0;
    s1_strobe = 1'b0;

    // drop counter saturation under sustained backpressure
    reset = 1'b1; bus.m_ready = 1'b0;
    step();
    reset = 1'b0;
    for (int k = 0; k < 300; k++) begin
      s0_strobe = 1'b1;
      s0_data   = mk(16'(1000 + k));
      s0_flags  = 2'b11;
      step();
      if (k == 9) chk("drop_cnt0_mid", k, 128'(drop_cnt0), 128'(8));
    end
    s0_strobe = 1'b0;
    chk("drop_cnt0_sat", 300, 128'(drop_cnt0), 128'(255));
    chk("drop_cnt1_sat", 300, 128'(drop_cnt1), 128'(0));
    chk("m_valid_sat",   300, 128'(bus.m_valid), 128'(1));
    chk("m_data_sat",    300, 128'(bus.m_data), 128'(mk(16'd1000)));

`ifndef LINK_WATCHDOG_EN
    // link stays up through silence; latest overwritten sample follows release
    repeat (40) step();
    chk("link_up_hold", 0, 128'(link_up), 128'(2'b01));
    bus.m_ready = 1'b1;
    step();
    chk("m_valid_gap", 0, 128'(bus.m_valid), 128'(0));
    step();
    chk("m_valid_last", 0, 128'(bus.m_valid), 128'(1));
    chk("m_data_last",  0, 128'(bus.m_data), 128'(mk(16'd1299)));
`else
    // stale source is dropped while the other source is in SEND
    reset = 1'b1;
    step();
    reset = 1'b0; bus.m_ready = 1'b0;
    s1_strobe = 1'b1; s1_data = mk(16'd500); s1_flags = 2'b11;
    step();
    s1_strobe = 1'b0;
    s0_strobe = 1'b1; s0_data = mk(16'd600); s0_flags = 2'b11;
    step();
    s0_strobe = 1'b0;
    chk("wd_m_valid", 0, 128'(bus.m_valid), 128'(1));
    chk("wd_m_src",   0, 128'(bus.m_src), 128'(1));
    repeat (9) step();
    chk("wd_link_a", 0, 128'(link_up), 128'(2'b01));
    step();
    chk("wd_link_b", 0, 128'(link_up), 128'(2'b00));
    bus.m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("wd_no_send", k, 128'(bus.m_valid), 128'(0));
    end
    s0_strobe = 1'b1;
    step();
    s0_strobe = 1'b0;
    chk("wd_link_c", 0, 128'(link_up), 128'(2'b01));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imu_frame_arbiter.md
IMU_FRAME_ARBITER -- requirements
Module: imu_frame_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 3000000, is the number of clk cycles without a sample before a source is declared stale (1 s at 3 MHz).
REQ-002 Parameter DROP_W, default 8, is the width of each dropped-sample counter.
REQ-003 clk  input  1  FPGA system clock; the only clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 s0_strobe  input  1  one-cycle pulse: new sample from source 0 on s0_data/s0_flags.
REQ-006 s0_data  input  112  {w,x,y,z,gx,gy,gz}, seven signed 16-bit fields, w in MSBs.
REQ-007 s0_flags  input  2  bit0 = orientation valid, bit1 = gyro valid.
REQ-008 s1_strobe / s1_data / s1_flags  input  1/112/2  same as source 0, for source 1.
REQ-009 m_valid  output  1  output sample is presented.
REQ-010 m_ready  input  1  downstream MCU-side formatter accepts the sample.
REQ-011 m_src  output  1  source index of the presented sample.
REQ-012 m_data / m_flags  output  112/2  presented sample.
REQ-013 drop_cnt0 / drop_cnt1  output  DROP_W  overwritten-unsent sample counts per source.
REQ-014 link_up  output  2  per-source link-alive status.

Function
REQ-015 A strobe on source i SHALL load holding register i and set pend[i] on the next clk edge.
REQ-016 A strobe while pend[i]=1 SHALL overwrite holding register i and increment drop_cnt i, saturating at all-ones.
REQ-017 FSM states: IDLE (m_valid=0) and SEND (m_valid=1).
REQ-018 IDLE with no pend bit set SHALL stay in IDLE.
REQ-019 IDLE with any pend bit set SHALL grant one source, copy its holding register to m_data/m_flags/m_src, clear its pend bit, and enter SEND on the same edge.
REQ-020 Grant SHALL be round-robin: if both are pending, grant the source not granted last. Otherwise grant the only pending source.
REQ-021 A strobe on the granted source in the grant cycle SHALL leave pend set with the new data. The old data is the one sent, and no drop is counted.
REQ-022 In SEND, m_data, m_flags and m_src SHALL hold stable until m_valid&&m_ready.
REQ-023 On m_valid&&m_ready the FSM SHALL return to IDLE, which gives a minimum one-cycle m_valid gap between transfers.
REQ-024 Latency: strobe at edge N gives pend=1 after N, and m_valid=1 after edge N+1 when the FSM is IDLE and no other source is granted.
REQ-025 Source 1 holding register, pend bit and counters SHALL be fully independent of source 0. Simultaneous strobes on both sources SHALL both be captured.

Reset
REQ-026 reset SHALL force the FSM to IDLE, m_valid=0, m_src=0, m_data=0, m_flags=0, pend=0, drop_cnt0=drop_cnt1=0, link_up=0, and watchdog counters=0.
REQ-027 After reset, the round-robin pointer SHALL favour source 0.
REQ-028 reset asserted during SEND SHALL abort the transfer with no handshake completion.
REQ-029 reset SHALL take priority over simultaneous strobes.

Configuration
REQ-030 Macro LINK_WATCHDOG_EN SHALL select the link_up behaviour.
REQ-031 With LINK_WATCHDOG_EN defined:
- each source has a counter that clears on a strobe and increments otherwise, saturating at TIMEOUT_CYCLES;
- link_up[i] SHALL set on a strobe and clear when the counter reaches TIMEOUT_CYCLES;
- on that same edge, pend[i] SHALL be cleared so the stale sample is discarded;
- a sample already in SEND is unaffected.
REQ-032 Without LINK_WATCHDOG_EN, no watchdog counters SHALL exist, and link_up[i] SHALL set on the first strobe of source i and remain set until reset.

Verification
REQ-033 Single sample: s0_strobe with data w=16384, x=100, flags=2'b11, m_ready=1 -> m_valid high 2 cycles after the strobe edge for 1 cycle, m_src=0, data and flags match.
REQ-034 Dual contention: s0 and s1 strobe in the same cycle, m_ready=1 -> source 0 sent first, then source 1 after a 1-cycle gap. Repeating this gives 1 then 0.
REQ-035 Backpressure/overwrite: m_ready=0, s1 strobes x=5, x=6, x=7 -> first sample held at x=5 in SEND, drop_cnt1=1. Releasing m_ready delivers x=5 then x=7.
REQ-036 Saturation: 300 s0 strobes with m_ready=0 -> drop_cnt0=255.
REQ-037 Watchdog (LINK_WATCHDOG_EN, TIMEOUT_CYCLES=10): one s0 strobe then silence -> link_up[0]=1, then 0 after 10 cycles, and pend[0] cleared. A new strobe restores link_up[0]=1.
REQ-038 Reset mid-SEND: m_ready=0, m_valid=1, then pulse reset -> next cycle all outputs 0. A subsequent strobe is sent normally.
